// File: rtl/pixel_writeback_arbiter_if.sv
// rtl/pixel_writeback_arbiter_if.sv - core-side and FIFO-side signal bundle for pixel_writeback_arbiter
// Ports (interface members):
//   core_req       NUM_CORES         level request, one bit per core
//   core_wvalid    NUM_CORES         core word valid
//   core_wdata     NUM_CORES*DATA_W  core c's word on [c*DATA_W +: DATA_W]
//   core_grant     NUM_CORES         one-hot grant back to the cores
//   core_ack       NUM_CORES         one-hot word-accepted strobe
//   FF_pixel_full  1                 output FIFO full
//   FF_pixel_wrreq 1                 FIFO write strobe
//   FF_pixel_data  DATA_W            FIFO write data
// Modports: master = cores and FIFO side, slave = arbiter.
interface pixel_writeback_arbiter_if #(
    parameter int NUM_CORES = 87,
    parameter int DATA_W    = 32
);
    logic [NUM_CORES-1:0]        core_req;
    logic [NUM_CORES-1:0]        core_wvalid;
    logic [NUM_CORES*DATA_W-1:0] core_wdata;
    logic [NUM_CORES-1:0]        core_grant;
    logic [NUM_CORES-1:0]        core_ack;
    logic                        FF_pixel_full;
    logic                        FF_pixel_wrreq;
    logic [DATA_W-1:0]           FF_pixel_data;

    modport master (
        output core_req, core_wvalid, core_wdata, FF_pixel_full,
        input  core_grant, core_ack, FF_pixel_wrreq, FF_pixel_data
    );

    modport slave (
        input  core_req, core_wvalid, core_wdata, FF_pixel_full,
        output core_grant, core_ack, FF_pixel_wrreq, FF_pixel_data
    );
endinterface

// File: rtl/pixel_writeback_arbiter.sv
// rtl/pixel_writeback_arbiter.sv - round-robin arbiter sharing the pixel FIFO among render cores
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          pixel_writeback_arbiter_if.slave (requests, burst words, grant/ack, FIFO write)
//   busy         high whenever the FSM is not IDLE
//   burst_count  completed bursts, wraps at 2^32
//   count_clr    synchronous clear of burst_count and the error flags
//   err_timeout  sticky watchdog error
//   err_core_id  core that timed out
// Optional feature: define PIXEL_WB_TIMEOUT_EN to enable the XFER watchdog
// (TIMEOUT_CYC consecutive cycles without core_wvalid aborts the burst).
module pixel_writeback_arbiter #(
    parameter int NUM_CORES   = 87,
    parameter int CORE_ID_W   = 7,
    parameter int DATA_W      = 32,
    parameter int BURST_LEN   = 3,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    pixel_writeback_arbiter_if.slave bus,
    output logic                     busy,
    output logic [31:0]              burst_count,
    input  logic                     count_clr,
    output logic                     err_timeout,
    output logic [CORE_ID_W-1:0]     err_core_id
);
    localparam int WC_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [1:0] {IDLE, XFER, RELEASE} state_t;

    state_t                 state, next_state;
    logic [NUM_CORES-1:0]   grant_q;
    logic [CORE_ID_W-1:0]   g;
    logic [CORE_ID_W-1:0]   rr_ptr;
    logic [WC_W-1:0]        word_cnt;
    logic                   win_found;
    logic [CORE_ID_W-1:0]   win_idx;
    logic [DATA_W-1:0]      sel_data;
    logic                   accept;
    logic                   done;
    logic                   abort;
    logic                   wrreq;
    logic [NUM_CORES-1:0]   ack;
    logic [DATA_W-1:0]      data;
`ifdef PIXEL_WB_TIMEOUT_EN
    localparam int IDLE_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [IDLE_W-1:0]      idle_cnt;
`endif

    // Rotating priority: scan from rr_ptr upward, wrapping at NUM_CORES.
    always_comb begin
        logic [CORE_ID_W:0] idx_ext;
        logic [CORE_ID_W-1:0] idx;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            idx_ext = {1'b0, rr_ptr} + (CORE_ID_W+1)'(i);
            if (idx_ext >= (CORE_ID_W+1)'(NUM_CORES))
                idx_ext = idx_ext - (CORE_ID_W+1)'(NUM_CORES);
            idx = idx_ext[CORE_ID_W-1:0];
            if (!win_found && bus.core_req[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int c = 0; c < NUM_CORES; c++)
            if (CORE_ID_W'(c) == g)
                sel_data = bus.core_wdata[c*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Write strobes are gated by state so an async reset drops them immediately.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        done       = 1'b0;
        abort      = 1'b0;
        wrreq      = 1'b0;
        ack        = '0;
        data       = '0;
        busy       = (state != IDLE);
        case (state)
            IDLE: if (win_found) next_state = XFER;
            XFER: begin
                accept = bus.core_wvalid[g] && !bus.FF_pixel_full;
                if (accept) begin
                    wrreq = 1'b1;
                    ack   = grant_q;
                    data  = sel_data;
                    if (word_cnt == WC_W'(BURST_LEN-1)) begin
                        done       = 1'b1;
                        next_state = RELEASE;
                    end
                end
`ifdef PIXEL_WB_TIMEOUT_EN
                else if (!bus.core_wvalid[g] && idle_cnt == IDLE_W'(TIMEOUT_CYC-1)) begin
                    abort      = 1'b1;
                    next_state = RELEASE;
                end
`endif
            end
            RELEASE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign bus.core_grant     = grant_q;
    assign bus.core_ack       = ack;
    assign bus.FF_pixel_wrreq = wrreq;
    assign bus.FF_pixel_data  = data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q     <= '0;
            g           <= '0;
            rr_ptr      <= '0;
            word_cnt    <= '0;
            burst_count <= '0;
        end else begin
            case (state)
                IDLE: if (win_found) begin
                    g        <= win_idx;
                    grant_q  <= NUM_CORES'(1) << win_idx;
                    word_cnt <= '0;
                end
                XFER: begin
                    if (accept)
                        word_cnt <= word_cnt + WC_W'(1);
                    if (next_state == RELEASE)
                        grant_q <= '0;
                end
                RELEASE: rr_ptr <= (g == CORE_ID_W'(NUM_CORES-1)) ? '0 : g + CORE_ID_W'(1);
                default: ;
            endcase
            if (count_clr)
                burst_count <= '0;
            else if (done)
                burst_count <= burst_count + 32'd1;
        end
    end

`ifdef PIXEL_WB_TIMEOUT_EN
    // Only cycles with wvalid low count; FIFO-full stalls with valid high reset the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt    <= '0;
            err_timeout <= 1'b0;
            err_core_id <= '0;
        end else begin
            if (state != XFER || bus.core_wvalid[g])
                idle_cnt <= '0;
            else if (!abort)
                idle_cnt <= idle_cnt + IDLE_W'(1);
            if (count_clr) begin
                err_timeout <= 1'b0;
                err_core_id <= '0;
            end else if (abort) begin
                err_timeout <= 1'b1;
                err_core_id <= g;
            end
        end
    end
`else
    assign err_timeout = 1'b0;
    assign err_core_id = '0;
`endif
endmodule

// File: tb/tb_pixel_writeback_arbiter.sv
// tb/tb_pixel_writeback_arbiter.sv - directed self-checking bench for pixel_writeback_arbiter
module tb_pixel_writeback_arbiter;
    localparam int NC = 87;
    localparam int DW = 32;
    localparam int IW = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          busy;
    logic [31:0]   burst_count;
    logic          count_clr;
    logic          err_timeout;
    logic [IW-1:0] err_core_id;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int grant_seq[$];
    int wr_cnt;
    int overlap;

    pixel_writeback_arbiter_if #(.NUM_CORES(NC), .DATA_W(DW)) bus ();

    pixel_writeback_arbiter #(
        .NUM_CORES(NC), .CORE_ID_W(IW), .DATA_W(DW), .BURST_LEN(3), .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .burst_count(burst_count),
        .count_clr(count_clr), .err_timeout(err_timeout), .err_core_id(err_core_id)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(int c, int k);
        logic [7:0] cb, kb;
        cb = c[7:0];
        kb = k[7:0];
        return {8'hC0, cb, 8'h5A, kb};
    endfunction

    function automatic logic [NC-1:0] bit_of(int c);
        logic [NC-1:0] one;
        one = NC'(1);
        return one << c;
    endfunction

    function automatic int first_set(logic [NC-1:0] v);
        for (int i = 0; i < NC; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    // Advance one clock; inputs are re-driven 1 unit after the edge, outputs checked 2 units after.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int c = 0; c < NC; c++)
            bus.core_wdata[c*DW +: DW] = pat(c, cyc);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic run(int n);
        logic [NC-1:0] prev;
        prev = '0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.core_grant != '0 && bus.core_grant != prev)
                grant_seq.push_back(first_set(bus.core_grant));
            if (!$onehot0(bus.core_grant)) overlap++;
            if (bus.FF_pixel_wrreq) wr_cnt++;
            prev = bus.core_grant;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.core_grant !== '0) begin n_fail++; $display("FAIL reset_grant got %h want 0", bus.core_grant); end
        n_checks++; if (bus.FF_pixel_wrreq !== 1'b0 || bus.FF_pixel_data !== '0) begin n_fail++; $display("FAIL reset_fifo got wrreq=%b data=%h want 0/0", bus.FF_pixel_wrreq, bus.FF_pixel_data); end
        n_checks++; if (busy !== 1'b0 || burst_count !== 32'd0) begin n_fail++; $display("FAIL reset_status got busy=%b count=%0d want 0/0", busy, burst_count); end
        n_checks++; if (err_timeout !== 1'b0 || err_core_id !== '0 || bus.core_ack !== '0) begin n_fail++; $display("FAIL reset_err got err=%b id=%0d ack=%h want 0", err_timeout, err_core_id, bus.core_ack); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [NC-1:0] eg [6];
        logic          ew [6];
        logic          eb [6];
        eg = '{'0, bit_of(5), bit_of(5), bit_of(5), '0, '0};
        ew = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        eb = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        bus.core_wvalid = '1;
        bus.core_req    = bit_of(5);
        #1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) tick();
            if (k == 1) begin bus.core_req = '0; #1; end
            n_checks++; if (bus.core_grant !== eg[k]) begin n_fail++; $display("FAIL single_grant c%0d got %h want %h", k, bus.core_grant, eg[k]); end
            n_checks++; if (bus.FF_pixel_wrreq !== ew[k] || busy !== eb[k]) begin n_fail++; $display("FAIL single_wr c%0d got wrreq=%b busy=%b want %b/%b", k, bus.FF_pixel_wrreq, busy, ew[k], eb[k]); end
            if (ew[k]) begin
                n_checks++; if (bus.FF_pixel_data !== pat(5, cyc) || bus.core_ack !== bit_of(5)) begin n_fail++; $display("FAIL single_data c%0d got %h ack=%h want %h", k, bus.FF_pixel_data, bus.core_ack, pat(5, cyc)); end
            end
        end
        n_checks++; if (burst_count !== 32'd1) begin n_fail++; $display("FAIL single_count got %0d want 1", burst_count); end
    endtask

    task automatic test_contention();
        do_reset();
        bus.core_wvalid = '1;
        bus.core_req    = bit_of(0) | bit_of(40) | bit_of(86);
        grant_seq.delete(); wr_cnt = 0; overlap = 0;
        run(20);
        bus.core_req = '0;
        n_checks++; if (grant_seq.size() != 4) begin n_fail++; $display("FAIL contention_ngrants got %0d want 4", grant_seq.size()); end
        else begin
            n_checks++; if (grant_seq[0] != 0 || grant_seq[1] != 40 || grant_seq[2] != 86 || grant_seq[3] != 0) begin n_fail++; $display("FAIL contention_order got %0d,%0d,%0d,%0d want 0,40,86,0", grant_seq[0], grant_seq[1], grant_seq[2], grant_seq[3]); end
        end
        n_checks++; if (overlap != 0 || wr_cnt != 12) begin n_fail++; $display("FAIL contention_writes got overlap=%0d writes=%0d want 0/12", overlap, wr_cnt); end
        n_checks++; if (burst_count !== 32'd4) begin n_fail++; $display("FAIL contention_count got %0d want 4", burst_count); end
        run(6);
    endtask

    task automatic test_wrap();
        do_reset();
        bus.core_wvalid = '1;
        bus.core_req    = bit_of(85);
        tick();
        bus.core_req = '0;
        run(4);
        bus.core_req = bit_of(86) | bit_of(2);
        grant_seq.delete(); wr_cnt = 0; overlap = 0;
        run(10);
        bus.core_req = '0;
        n_checks++; if (grant_seq.size() != 2) begin n_fail++; $display("FAIL wrap_ngrants got %0d want 2", grant_seq.size()); end
        else begin
            n_checks++; if (grant_seq[0] != 86 || grant_seq[1] != 2) begin n_fail++; $display("FAIL wrap_order got %0d,%0d want 86,2", grant_seq[0], grant_seq[1]); end
        end
        n_checks++; if (wr_cnt != 6 || overlap != 0) begin n_fail++; $display("FAIL wrap_writes got %0d overlap=%0d want 6/0", wr_cnt, overlap); end
        run(6);
    endtask

    task automatic test_backpressure();
        int writes;
        do_reset();
        bus.core_wvalid = '1;
        bus.core_req    = bit_of(7);
        tick();
        bus.core_req = '0;
        #1;
        writes = 0;
        n_checks++; if (bus.FF_pixel_wrreq !== 1'b1 || bus.FF_pixel_data !== pat(7, cyc)) begin n_fail++; $display("FAIL bp_word0 got wrreq=%b data=%h want 1/%h", bus.FF_pixel_wrreq, bus.FF_pixel_data, pat(7, cyc)); end
        if (bus.FF_pixel_wrreq) writes++;
        for (int k = 0; k < 4; k++) begin
            tick();
            bus.FF_pixel_full = 1'b1;
            #1;
            n_checks++; if (bus.FF_pixel_wrreq !== 1'b0 || bus.core_ack !== '0 || bus.FF_pixel_data !== '0) begin n_fail++; $display("FAIL bp_stall%0d got wrreq=%b ack=%h data=%h want 0", k, bus.FF_pixel_wrreq, bus.core_ack, bus.FF_pixel_data); end
            n_checks++; if (bus.core_grant !== bit_of(7)) begin n_fail++; $display("FAIL bp_hold%0d got %h want %h", k, bus.core_grant, bit_of(7)); end
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            bus.FF_pixel_full = 1'b0;
            #1;
            if (bus.FF_pixel_wrreq) writes++;
            if (k == 0) begin
                n_checks++; if (bus.FF_pixel_data !== pat(7, cyc)) begin n_fail++; $display("FAIL bp_word1 got %h want %h", bus.FF_pixel_data, pat(7, cyc)); end
            end
        end
        n_checks++; if (writes != 3) begin n_fail++; $display("FAIL bp_writes got %0d want 3", writes); end
        n_checks++; if (burst_count !== 32'd1 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_done got count=%0d busy=%b want 1/0", burst_count, busy); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.core_wvalid = '1;
        bus.core_req    = bit_of(9);
        tick();
        tick();
        n_checks++; if (bus.FF_pixel_wrreq !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got wrreq=%b want 1", bus.FF_pixel_wrreq); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.FF_pixel_wrreq !== 1'b0 || bus.FF_pixel_data !== '0 || bus.core_ack !== '0) begin n_fail++; $display("FAIL rstmid_fifo got wrreq=%b data=%h ack=%h want 0", bus.FF_pixel_wrreq, bus.FF_pixel_data, bus.core_ack); end
        n_checks++; if (bus.core_grant !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_state got grant=%h busy=%b want 0/0", bus.core_grant, busy); end
        bus.core_req = '0;
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b0 || burst_count !== 32'd0) begin n_fail++; $display("FAIL rstmid_after got busy=%b count=%0d want 0/0", busy, burst_count); end
    endtask

    task automatic test_count_clr();
        do_reset();
        bus.core_wvalid = '1;
        bus.core_req    = bit_of(3);
        tick();
        bus.core_req = '0;
        run(4);
        n_checks++; if (burst_count !== 32'd1) begin n_fail++; $display("FAIL clr_first got %0d want 1", burst_count); end
        bus.core_req = bit_of(3);
        tick();
        bus.core_req = '0;
        tick();
        tick();
        count_clr = 1'b1;
        tick();
        count_clr = 1'b0;
        n_checks++; if (burst_count !== 32'd0) begin n_fail++; $display("FAIL clr_priority got %0d want 0", burst_count); end
        tick();
        n_checks++; if (burst_count !== 32'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL clr_after got count=%0d busy=%b want 0/0", burst_count, busy); end
    endtask

    task automatic test_watchdog();
        do_reset();
        bus.core_wvalid = '0;
        bus.core_req    = bit_of(4);
        tick();
        bus.core_req = '0;
        for (int k = 2; k <= 8; k++) tick();
        n_checks++; if (bus.core_grant !== bit_of(4) || bus.FF_pixel_wrreq !== 1'b0) begin n_fail++; $display("FAIL wd_wait got grant=%h wrreq=%b want %h/0", bus.core_grant, bus.FF_pixel_wrreq, bit_of(4)); end
        tick();
`ifdef PIXEL_WB_TIMEOUT_EN
        n_checks++; if (bus.core_grant !== '0 || busy !== 1'b1) begin n_fail++; $display("FAIL wd_abort got grant=%h busy=%b want 0/1", bus.core_grant, busy); end
        n_checks++; if (err_timeout !== 1'b1 || err_core_id !== 7'd4 || burst_count !== 32'd0) begin n_fail++; $display("FAIL wd_err got err=%b id=%0d count=%0d want 1/4/0", err_timeout, err_core_id, burst_count); end
        tick();
        count_clr = 1'b1;
        tick();
        count_clr = 1'b0;
        n_checks++; if (err_timeout !== 1'b0 || err_core_id !== '0) begin n_fail++; $display("FAIL wd_clear got err=%b id=%0d want 0/0", err_timeout, err_core_id); end
`else
        n_checks++; if (bus.core_grant !== bit_of(4) || err_timeout !== 1'b0 || err_core_id !== '0) begin n_fail++; $display("FAIL wd_off got grant=%h err=%b id=%0d want %h/0/0", bus.core_grant, err_timeout, err_core_id, bit_of(4)); end
        bus.core_wvalid = '1;
        run(5);
        n_checks++; if (burst_count !== 32'd1 || busy !== 1'b0) begin n_fail++; $display("FAIL wd_resume got count=%0d busy=%b want 1/0", burst_count, busy); end
`endif
    endtask

    initial begin
        rst_n             = 1'b0;
        count_clr         = 1'b0;
        bus.core_req      = '0;
        bus.core_wvalid   = '0;
        bus.core_wdata    = '0;
        bus.FF_pixel_full = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_count_clr();
        test_watchdog();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
